// File: rtl/uart_rx_sampler_pkg.sv
// Shared definitions for the UART receive sampler: FSM states, oversampling
// constants and the baud divider calculation.
// UART_RX_PARITY_EN adds the PARITY state for 8E1 frames.
package uart_pkg;

   localparam int unsigned OVERSAMPLE = 16;
   localparam int unsigned SAMPLE_A   = 7;
   localparam int unsigned SAMPLE_B   = 8;
   localparam int unsigned SAMPLE_C   = 9;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_STOP   = 3'd3,
      ST_BREAK  = 3'd4
`ifdef UART_RX_PARITY_EN
      , ST_PARITY = 3'd5
`endif
   } uart_state_e;

   // Clocks per oversample tick, rounded to nearest and never below 1.
   function automatic int unsigned calc_div(input int unsigned fmax_mhz,
                                            input int unsigned baud);
      longint unsigned num;
      longint unsigned den;
      longint unsigned q;
      num = fmax_mhz;
      num = num * 64'd1000000;
      den = baud;
      den = den * OVERSAMPLE;
      if (den == 0) return 1;
      q = (num + den / 2) / den;
      if (q < 1) q = 1;
      return q[31:0];
   endfunction

endpackage

// File: rtl/uart_rx_sampler_if.sv
// Receiver-side signal bundle: serial line in, received byte and status pulses out.
// UART_RX_PARITY_EN adds the parity_err pulse.
interface uart_rx_sampler_if;

   logic       uart_rx;
   logic [7:0] rdata;
   logic       rdata_valid;
   logic       frame_err;
   logic       busy;
`ifdef UART_RX_PARITY_EN
   logic       parity_err;

   modport master (input uart_rx, output rdata, output rdata_valid,
                   output frame_err, output busy, output parity_err);
   modport slave  (output uart_rx, input rdata, input rdata_valid,
                   input frame_err, input busy, input parity_err);
`else
   modport master (input uart_rx, output rdata, output rdata_valid,
                   output frame_err, output busy);
   modport slave  (output uart_rx, input rdata, input rdata_valid,
                   input frame_err, input busy);
`endif

endinterface

// File: rtl/uart_rx_sampler_baud_tick.sv
// Oversample tick generator: free-running divider that pulses tick once
// every DIV clocks; restart realigns the divider to the current cycle.
module uart_baud_tick #(
   parameter int unsigned DIV = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic restart,
   output logic tick
);

   localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   // Divider count: wraps at DIV-1, forced to zero on restart.
   always_comb begin
      cnt_d = cnt_q;
      if (restart)
         cnt_d = '0;
      else if (cnt_q == LAST)
         cnt_d = '0;
      else
         cnt_d = cnt_q + 1'b1;
   end

   // Divider register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign tick = (cnt_q == LAST);

endmodule

// File: rtl/uart_rx_sampler.sv
// UART receiver with 16x oversampling and 3-sample majority vote per bit.
// Default build receives 8N1; defining UART_RX_PARITY_EN adds an even-parity
// bit and the parity_err pulse.
module uart_rx_sampler
   import uart_pkg::*;
#(
   parameter int unsigned FMAX_MHz = 27,
   parameter int unsigned BAUD     = 115200
) (
   input  logic              clk,
   input  logic              rst,
   uart_rx_sampler_if.master bus
);

   localparam int unsigned DIV      = calc_div(FMAX_MHz, BAUD);
   localparam logic [3:0]  IDX_A    = 4'(SAMPLE_A);
   localparam logic [3:0]  IDX_B    = 4'(SAMPLE_B);
   localparam logic [3:0]  IDX_C    = 4'(SAMPLE_C);
   localparam logic [3:0]  IDX_LAST = 4'(OVERSAMPLE - 1);

   uart_state_e state_q, state_d;

   logic       sync1_q, sync1_d;
   logic       sync2_q, sync2_d;
   logic       prev_q, prev_d;
   logic [3:0] tick_cnt_q, tick_cnt_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [7:0] shift_q, shift_d;
   logic [1:0] votes_q, votes_d;
   logic [7:0] rdata_q, rdata_d;
   logic       valid_q, valid_d;
   logic       ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
   logic       perr_q, perr_d;
   logic       par_bad_q, par_bad_d;
`endif

   logic rx_s;
   logic fall;
   logic start_accept;
   logic tick;
   logic decide;
   logic majority;

   assign rx_s         = sync2_q;
   assign fall         = prev_q & ~sync2_q;
   assign start_accept = (state_q == ST_IDLE) && fall;
   // Each bit is resolved on its last vote tick; the state for the next bit
   // takes over for the remaining ticks, which leaves room for a new start
   // edge in the tail of the stop bit.
   assign decide       = tick && (tick_cnt_q == IDX_C);
   assign majority     = (votes_q[1] & votes_q[0]) | (votes_q[1] & rx_s) | (votes_q[0] & rx_s);

   uart_baud_tick #(.DIV(DIV)) u_baud_tick (
      .clk     (clk),
      .rst     (rst),
      .restart (start_accept),
      .tick    (tick)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // Next-state selection from edges and per-bit majority decisions.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (fall)   state_d = ST_START;
         ST_START:  if (decide) state_d = majority ? ST_IDLE : ST_DATA;
`ifdef UART_RX_PARITY_EN
         ST_DATA:   if (decide && bit_cnt_q == 3'd7) state_d = ST_PARITY;
         ST_PARITY: if (decide) state_d = ST_STOP;
`else
         ST_DATA:   if (decide && bit_cnt_q == 3'd7) state_d = ST_STOP;
`endif
         ST_STOP:   if (decide) state_d = majority ? ST_IDLE : ST_BREAK;
         ST_BREAK:  if (rx_s)   state_d = ST_IDLE;
         default:               state_d = ST_IDLE;
      endcase
   end

   // Datapath and output pulses: synchronizer, tick/bit counters, votes, shift register.
   always_comb begin
      sync1_d    = bus.uart_rx;
      sync2_d    = sync1_q;
      prev_d     = sync2_q;
      tick_cnt_d = tick_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      votes_d    = votes_q;
      rdata_d    = rdata_q;
      valid_d    = 1'b0;
      ferr_d     = 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_d     = 1'b0;
      par_bad_d  = par_bad_q;
`endif

      if (start_accept)
         tick_cnt_d = '0;
      else if (tick && state_q != ST_IDLE)
         tick_cnt_d = (tick_cnt_q == IDX_LAST) ? '0 : tick_cnt_q + 4'd1;

      if (tick && tick_cnt_q == IDX_A) votes_d[1] = rx_s;
      if (tick && tick_cnt_q == IDX_B) votes_d[0] = rx_s;

      if (decide) begin
         case (state_q)
            ST_START: bit_cnt_d = '0;
            ST_DATA: begin
               shift_d   = {majority, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: par_bad_d = (^shift_q) ^ majority;
`endif
            ST_STOP: begin
               if (!majority)
                  ferr_d = 1'b1;
`ifdef UART_RX_PARITY_EN
               else if (par_bad_q)
                  perr_d = 1'b1;
`endif
               else begin
                  valid_d = 1'b1;
                  rdata_d = shift_q;
               end
            end
            default: ;
         endcase
      end
   end

   // Datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q    <= 1'b1;
         sync2_q    <= 1'b1;
         prev_q     <= 1'b1;
         tick_cnt_q <= '0;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         votes_q    <= '1;
         rdata_q    <= '0;
         valid_q    <= 1'b0;
         ferr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
         perr_q     <= 1'b0;
         par_bad_q  <= 1'b0;
`endif
      end else begin
         sync1_q    <= sync1_d;
         sync2_q    <= sync2_d;
         prev_q     <= prev_d;
         tick_cnt_q <= tick_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         votes_q    <= votes_d;
         rdata_q    <= rdata_d;
         valid_q    <= valid_d;
         ferr_q     <= ferr_d;
`ifdef UART_RX_PARITY_EN
         perr_q     <= perr_d;
         par_bad_q  <= par_bad_d;
`endif
      end
   end

   assign bus.rdata       = rdata_q;
   assign bus.rdata_valid = valid_q;
   assign bus.frame_err   = ferr_q;
   assign bus.busy        = (state_q != ST_IDLE);
`ifdef UART_RX_PARITY_EN
   assign bus.parity_err  = perr_q;
`endif

endmodule
